// File: rtl/key_debounce_pkg.sv
// Shared types and defaults for the push-button debouncer.
// Channel state encoding, default timing constants and key polarity.
package key_pkg;

  typedef enum logic [1:0] {
    IDLE         = 2'b00,
    PRESS_WAIT   = 2'b01,
    HELD         = 2'b10,
    RELEASE_WAIT = 2'b11
  } key_state_t;

  localparam int NUM_KEYS = 2;

  localparam int DEF_DEBOUNCE_CYCLES = 1000;
  localparam int DEF_REPEAT_DELAY    = 25000000;
  localparam int DEF_REPEAT_PERIOD   = 5000000;

  // Board keys pull low when pressed.
  localparam logic KEY_ACTIVE = 1'b0;

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/key_debounce_ch.sv
// One key channel: 2-flop synchroniser, stable-time FSM, registered pulses.
// Auto-repeat while held is compiled in only when KEY_REPEAT_EN is defined.
module key_debounce_ch
  import key_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
  input  logic clk,
  input  logic rst,
  input  logic key,
  output logic press,
  output logic released,
  output logic held
);

  if (DEBOUNCE_CYCLES < 2 || REPEAT_DELAY < 2 || REPEAT_PERIOD < 2) begin : g_param_check
    $error("key_debounce_ch: timing parameters must be >= 2");
  end

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]    sync;
  logic          pressed;
  key_state_t    state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          press_nxt, rel_nxt;

  assign pressed = (sync[1] == KEY_ACTIVE);

`ifdef KEY_REPEAT_EN
  localparam int RW = $clog2(imax(REPEAT_DELAY, REPEAT_PERIOD));
  localparam logic [RW-1:0] DELAY_LAST  = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] PERIOD_LAST = RW'(REPEAT_PERIOD - 1);

  logic [RW-1:0] rep, rep_nxt;
  logic          rep_run, rep_run_nxt;  // 0: waiting out the initial delay
  logic          rep_fire;

  assign rep_fire = (rep == (rep_run ? PERIOD_LAST : DELAY_LAST));
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      sync     <= {2{~KEY_ACTIVE}};
      state    <= IDLE;
      cnt      <= '0;
      press    <= 1'b0;
      released <= 1'b0;
      held     <= 1'b0;
`ifdef KEY_REPEAT_EN
      rep      <= '0;
      rep_run  <= 1'b0;
`endif
    end else begin
      sync     <= {sync[0], key};
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      press    <= press_nxt;
      released <= rel_nxt;
      held     <= (state_nxt == HELD) || (state_nxt == RELEASE_WAIT);
`ifdef KEY_REPEAT_EN
      rep      <= rep_nxt;
      rep_run  <= rep_run_nxt;
`endif
    end
  end

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    press_nxt   = 1'b0;
    rel_nxt     = 1'b0;
`ifdef KEY_REPEAT_EN
    rep_nxt     = rep;
    rep_run_nxt = rep_run;
`endif
    case (state)
      IDLE: begin
        if (pressed) begin
          state_nxt = PRESS_WAIT;
          cnt_nxt   = '0;
        end
      end
      PRESS_WAIT: begin
        if (!pressed) begin
          state_nxt = IDLE;
        end else if (cnt == CNT_LAST) begin
          state_nxt = HELD;
          press_nxt = 1'b1;
`ifdef KEY_REPEAT_EN
          rep_nxt     = '0;
          rep_run_nxt = 1'b0;
`endif
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      HELD: begin
        if (!pressed) begin
          state_nxt = RELEASE_WAIT;
          cnt_nxt   = '0;
        end
`ifdef KEY_REPEAT_EN
        else if (rep_fire) begin
          press_nxt   = 1'b1;
          rep_nxt     = '0;
          rep_run_nxt = 1'b1;
        end else begin
          rep_nxt = rep + 1'b1;
        end
`endif
      end
      RELEASE_WAIT: begin
        // A bounce back to pressed resumes HELD silently; repeat timing is kept.
        if (pressed) begin
          state_nxt = HELD;
        end else if (cnt == CNT_LAST) begin
          state_nxt = IDLE;
          rel_nxt   = 1'b1;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
    endcase
  end

endmodule

// File: rtl/key_debounce.sv
// Two-key debouncer: one independent key_debounce_ch per raw active-low pin.
// Define KEY_REPEAT_EN to enable auto-repeat press pulses while a key is held.
// The release pulse port is named 'released' since 'release' is a reserved word.
module key_debounce
  import key_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_KEYS-1:0] keys,
  output logic [NUM_KEYS-1:0] press,
  output logic [NUM_KEYS-1:0] released,
  output logic [NUM_KEYS-1:0] held
);

  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_ch
    key_debounce_ch #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .REPEAT_DELAY   (REPEAT_DELAY),
      .REPEAT_PERIOD  (REPEAT_PERIOD)
    ) u_ch (
      .clk     (clk),
      .rst     (rst),
      .key     (keys[i]),
      .press   (press[i]),
      .released(released[i]),
      .held    (held[i])
    );
  end

endmodule

// File: tb/tb_key_debounce.sv
// Scoreboard bench for key_debounce: stimulus queues expected pulse events,
// a negedge monitor pops and compares whenever press or release is active.
module tb_key_debounce;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] keys = 2'b11;
  logic [1:0] press, released, held;

  int cyc    = 0;
  int checks = 0;
  int errors = 0;

  typedef struct {
    int         cyc;
    logic [1:0] p;
    logic [1:0] r;
    logic [1:0] h;
  } ev_t;

  ev_t exp_q[$];

`ifdef KEY_REPEAT_EN
  int rep_at[5] = '{15, 19, 23, 27, 31};
`endif

  key_debounce #(
    .DEBOUNCE_CYCLES(4),
    .REPEAT_DELAY   (8),
    .REPEAT_PERIOD  (4)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .keys    (keys),
    .press   (press),
    .released(released),
    .held    (held)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick(input int k);
    repeat (k) @(posedge clk);
    #1;
  endtask

  task automatic push(input int c, input logic [1:0] p, input logic [1:0] r, input logic [1:0] h);
    ev_t e;
    e.cyc = c;
    e.p   = p;
    e.r   = r;
    e.h   = h;
    exp_q.push_back(e);
  endtask

  task automatic chk(input string name, input logic [1:0] act, input logic [1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  // Monitor: every active pulse cycle must match the next expected event.
  always @(negedge clk) begin : monitor
    ev_t e;
    if (press !== 2'b00 || released !== 2'b00) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_event cyc %0d: press=%b release=%b held=%b, no event expected",
                 cyc, press, released, held);
      end else begin
        e = exp_q.pop_front();
        if (e.cyc != cyc || e.p !== press || e.r !== released || e.h !== held) begin
          errors++;
          $display("FAIL event: got cyc %0d press=%b release=%b held=%b, expected cyc %0d press=%b release=%b held=%b",
                   cyc, press, released, held, e.cyc, e.p, e.r, e.h);
        end
      end
    end
  end

  initial begin : stim
    int n;

    // Reset state
    rst  = 1'b1;
    keys = 2'b11;
    tick(3);
    chk("reset_press", press, 2'b00);
    chk("reset_release", released, 2'b00);
    chk("reset_held", held, 2'b00);
    rst = 1'b0;
    tick(3);

    // Clean press and release on key 0
    n = cyc;
    keys[0] = 1'b0;
    push(n + 7, 2'b01, 2'b00, 2'b01);
    tick(10);
    chk("clean_held", held, 2'b01);
    n = cyc;
    keys[0] = 1'b1;
    push(n + 7, 2'b00, 2'b01, 2'b00);
    tick(10);
    chk("clean_released_held", held, 2'b00);

    // Bounce reject on key 1: low bursts shorter than qualification
    for (int i = 0; i < 3; i++) begin
      keys[1] = 1'b0;
      tick(3);
      keys[1] = 1'b1;
      tick(3);
      chk("bounce_held", held, 2'b00);
    end
    tick(4);

    // Release bounce on key 0
    n = cyc;
    keys[0] = 1'b0;
    push(n + 7, 2'b01, 2'b00, 2'b01);
    tick(8);
    n = cyc;
    keys[0] = 1'b1;
    tick(2);
    keys[0] = 1'b0;
    tick(2);
    keys[0] = 1'b1;
    push(n + 11, 2'b00, 2'b01, 2'b00);
    tick(4);
    chk("rel_bounce_held", held, 2'b01);
    tick(8);
    chk("rel_bounce_done", held, 2'b00);

    // Simultaneous press and release on both keys
    n = cyc;
    keys = 2'b00;
    push(n + 7, 2'b11, 2'b00, 2'b11);
    tick(10);
    chk("simul_held", held, 2'b11);
    n = cyc;
    keys = 2'b11;
    push(n + 7, 2'b00, 2'b11, 2'b00);
    tick(10);

    // Reset during PRESS_WAIT with key 0 still low
    keys[0] = 1'b0;
    tick(4);
    rst = 1'b1;
    tick(1);
    chk("midrst_press", press, 2'b00);
    chk("midrst_release", released, 2'b00);
    chk("midrst_held", held, 2'b00);
    rst = 1'b0;
    n = cyc;
    push(n + 7, 2'b01, 2'b00, 2'b01);
    tick(10);
    n = cyc;
    keys[0] = 1'b1;
    push(n + 7, 2'b00, 2'b01, 2'b00);
    tick(10);

    // Long hold on key 0: repeats only when the feature is built in
    n = cyc;
    keys[0] = 1'b0;
    push(n + 7, 2'b01, 2'b00, 2'b01);
`ifdef KEY_REPEAT_EN
    foreach (rep_at[k]) push(n + rep_at[k], 2'b01, 2'b00, 2'b01);
`endif
    tick(30);
    keys[0] = 1'b1;
    push(n + 37, 2'b00, 2'b01, 2'b00);
    tick(12);
    chk("final_held", held, 2'b00);

    // Every expected event must have been observed
    tick(5);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      while (exp_q.size() != 0) begin
        ev_t e;
        e = exp_q.pop_front();
        $display("FAIL missing_event: got nothing, expected cyc %0d press=%b release=%b held=%b",
                 e.cyc, e.p, e.r, e.h);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
